// File: rtl/leaf_out_packetizer.sv
// rtl/leaf_out_packetizer.sv - wraps kernel stream words into addressed BFT packets
// Credits track free space in the destination input buffer; update packets replenish them.
module leaf_out_packetizer #(
    parameter int PACKET_BITS           = 49,
    parameter int PAYLOAD_BITS          = 32,
    parameter int NUM_LEAF_BITS         = 5,
    parameter int NUM_PORT_BITS         = 4,
    parameter int NUM_ADDR_BITS         = 7,
    parameter int NUM_BRAM_ADDR_BITS    = 7,
    parameter int FREESPACE_UPDATE_SIZE = 64
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [PACKET_BITS-1:0]  din_leaf_bft2interface,
    output logic [PACKET_BITS-1:0]  dout_leaf_interface2bft,
    input  logic                    resend,
    input  logic [PAYLOAD_BITS-1:0] din_leaf_user2interface,
    input  logic                    vld_user2interface,
    output logic                    ack_interface2user,
    output logic [7:0]              credit_cnt,
    output logic [31:0]             sent_cnt,
    output logic [31:0]             stall_cnt,
    output logic                    credit_overflow
);

    localparam logic [8:0] CREDIT_MAX = 9'(1 << NUM_BRAM_ADDR_BITS);
    localparam logic [8:0] UPD_SIZE   = 9'(FREESPACE_UPDATE_SIZE);
    localparam int         PORT_LSB   = PAYLOAD_BITS + NUM_ADDR_BITS;

    logic [PACKET_BITS-1:0]   r_out;
    logic                     r_pend;
    logic [NUM_ADDR_BITS-1:0] r_wptr;
    logic [7:0]               r_credit;
    logic                     r_cfg_en;
    logic [NUM_LEAF_BITS-1:0] r_dst_leaf;
    logic [NUM_PORT_BITS-1:0] r_dst_port;
    logic                     r_overflow;
    logic [31:0]              r_sent;
    logic [31:0]              r_stall;

    logic                     w_ctrl_vld;
    logic [NUM_PORT_BITS-1:0] w_ctrl_port;
    logic                     w_cfg;
    logic                     w_upd;
    logic                     w_ack;
    logic                     w_acc;
    logic                     w_emit;
    logic [8:0]               w_sum;
    logic                     w_clamp;
    logic [7:0]               w_credit_nxt;

    assign w_ctrl_vld  = din_leaf_bft2interface[PACKET_BITS-1];
    assign w_ctrl_port = din_leaf_bft2interface[PORT_LSB +: NUM_PORT_BITS];
    assign w_cfg       = w_ctrl_vld && (w_ctrl_port == NUM_PORT_BITS'(0));
    assign w_upd       = w_ctrl_vld && (w_ctrl_port == NUM_PORT_BITS'(1));

    assign w_ack  = r_cfg_en && (r_credit != 8'd0) && !resend && !r_pend;
    assign w_acc  = w_ack && vld_user2interface;
    assign w_emit = r_pend && !resend;

    // Accept only happens with credit != 0, so the subtraction never underflows.
    assign w_sum        = {1'b0, r_credit} + (w_upd ? UPD_SIZE : 9'd0) - (w_acc ? 9'd1 : 9'd0);
    assign w_clamp      = (w_sum > CREDIT_MAX);
    assign w_credit_nxt = w_clamp ? CREDIT_MAX[7:0] : w_sum[7:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cfg_en   <= 1'b0;
            r_dst_leaf <= '0;
            r_dst_port <= '0;
        end else if (w_cfg) begin
            r_cfg_en   <= din_leaf_bft2interface[PAYLOAD_BITS-1];
            r_dst_leaf <= din_leaf_bft2interface[NUM_PORT_BITS +: NUM_LEAF_BITS];
            r_dst_port <= din_leaf_bft2interface[NUM_PORT_BITS-1:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out  <= '0;
            r_pend <= 1'b0;
            r_wptr <= '0;
        end else if (w_acc) begin
            r_out  <= {1'b1, r_dst_leaf, r_dst_port, r_wptr, din_leaf_user2interface};
            r_pend <= 1'b1;
            r_wptr <= r_wptr + NUM_ADDR_BITS'(1);
        end else if (w_emit) begin
            r_pend <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_credit   <= CREDIT_MAX[7:0];
            r_overflow <= 1'b0;
        end else begin
            r_credit <= w_credit_nxt;
            if (w_clamp) begin
                r_overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sent  <= '0;
            r_stall <= '0;
        end else begin
            if (w_emit) begin
                r_sent <= r_sent + 32'd1;
            end
            if (vld_user2interface && !w_ack) begin
                r_stall <= r_stall + 32'd1;
            end
        end
    end

    assign dout_leaf_interface2bft = w_emit ? r_out : '0;
    assign ack_interface2user      = w_ack;
    assign credit_cnt              = r_credit;
    assign sent_cnt                = r_sent;
    assign stall_cnt               = r_stall;
    assign credit_overflow         = r_overflow;

endmodule

// File: tb/tb_leaf_out_packetizer.sv
// tb/tb_leaf_out_packetizer.sv - directed checks for leaf_out_packetizer
module tb_leaf_out_packetizer;

    logic        clk = 1'b0;
    logic        reset;
    logic [48:0] din_ctrl;
    logic [48:0] dout;
    logic        resend;
    logic [31:0] data;
    logic        vld;
    logic        ack;
    logic [7:0]  credit_cnt;
    logic [31:0] sent_cnt;
    logic [31:0] stall_cnt;
    logic        credit_overflow;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    leaf_out_packetizer dut (
        .clk                     (clk),
        .reset                   (reset),
        .din_leaf_bft2interface  (din_ctrl),
        .dout_leaf_interface2bft (dout),
        .resend                  (resend),
        .din_leaf_user2interface (data),
        .vld_user2interface      (vld),
        .ack_interface2user      (ack),
        .credit_cnt              (credit_cnt),
        .sent_cnt                (sent_cnt),
        .stall_cnt               (stall_cnt),
        .credit_overflow         (credit_overflow)
    );

    localparam logic [48:0] CFG_PKT = {1'b1, 5'd0, 4'd0, 7'd0, 32'h8000_0032};
    localparam logic [48:0] UPD_PKT = {1'b1, 5'd0, 4'd1, 7'd0, 32'h0000_0000};

    typedef struct {
        logic [48:0] din;
        logic        rs;
        logic        v;
        logic [31:0] d;
        logic [48:0] exp_dout;
        logic        exp_ack;
        logic [7:0]  exp_credit;
    } vec_t;

    vec_t vecs [10];

    function automatic logic [48:0] pkt(input logic [6:0] a, input logic [31:0] d);
        return {1'b1, 5'd3, 4'd2, a, d};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; din_ctrl = '0; resend = 1'b0; vld = 1'b0; data = '0;
        next_cycle();
        next_cycle();
        reset = 1'b0;
    endtask

    task automatic send_cfg();
        din_ctrl = CFG_PKT;
        next_cycle();
        din_ctrl = '0;
    endtask

    int acc;
    int emit;
    logic [31:0] s0;

    // Streams words numbered from acc; checks each emitted packet against its sequence index.
    task automatic stream(input int ncyc);
        for (int i = 0; i < ncyc; i++) begin
            vld  = 1'b1;
            data = 32'(acc);
            @(negedge clk);
            if (dout[48]) begin
                chk("stream_pkt", 64'(dout), 64'(pkt(7'(emit), 32'(emit))));
                emit++;
            end
            if (ack) acc++;
            next_cycle();
        end
    endtask

    initial begin
        reset = 1'b1; din_ctrl = '0; resend = 1'b0; vld = 1'b0; data = '0;
        #3;
        chk("rst_dout", 64'(dout), 64'd0);
        chk("rst_ack", 64'(ack), 64'd0);
        chk("rst_credit", 64'(credit_cnt), 64'd128);
        chk("rst_sent", 64'(sent_cnt), 64'd0);
        chk("rst_stall", 64'(stall_cnt), 64'd0);
        chk("rst_ovf", 64'(credit_overflow), 64'd0);
        next_cycle();
        reset = 1'b0;

        // Config then a 4-word burst, one row per cycle.
        vecs[0] = '{49'd0,   1'b0, 1'b0, 32'h0,  49'd0,             1'b0, 8'd128};
        vecs[1] = '{CFG_PKT, 1'b0, 1'b0, 32'h0,  49'd0,             1'b0, 8'd128};
        vecs[2] = '{49'd0,   1'b0, 1'b1, 32'hA0, 49'd0,             1'b1, 8'd128};
        vecs[3] = '{49'd0,   1'b0, 1'b1, 32'hA1, pkt(7'd0, 32'hA0), 1'b0, 8'd127};
        vecs[4] = '{49'd0,   1'b0, 1'b1, 32'hA1, 49'd0,             1'b1, 8'd127};
        vecs[5] = '{49'd0,   1'b0, 1'b1, 32'hA2, pkt(7'd1, 32'hA1), 1'b0, 8'd126};
        vecs[6] = '{49'd0,   1'b0, 1'b1, 32'hA2, 49'd0,             1'b1, 8'd126};
        vecs[7] = '{49'd0,   1'b0, 1'b1, 32'hA3, pkt(7'd2, 32'hA2), 1'b0, 8'd125};
        vecs[8] = '{49'd0,   1'b0, 1'b1, 32'hA3, 49'd0,             1'b1, 8'd125};
        vecs[9] = '{49'd0,   1'b0, 1'b0, 32'h0,  pkt(7'd3, 32'hA3), 1'b0, 8'd124};
        for (int i = 0; i < 10; i++) begin
            din_ctrl = vecs[i].din; resend = vecs[i].rs; vld = vecs[i].v; data = vecs[i].d;
            @(negedge clk);
            chk($sformatf("vec%0d_dout", i), 64'(dout), 64'(vecs[i].exp_dout));
            chk($sformatf("vec%0d_ack", i), 64'(ack), 64'(vecs[i].exp_ack));
            chk($sformatf("vec%0d_credit", i), 64'(credit_cnt), 64'(vecs[i].exp_credit));
            next_cycle();
        end
        vld = 1'b0;
        chk("burst_sent", 64'(sent_cnt), 64'd4);
        chk("burst_stall", 64'(stall_cnt), 64'd3);

        // Resend holds the pending packet for 3 cycles.
        vld = 1'b1; data = 32'h55;
        @(negedge clk);
        chk("rs_ack0", 64'(ack), 64'd1);
        next_cycle();
        vld = 1'b0; resend = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rs_hold_dout", 64'(dout), 64'd0);
            chk("rs_hold_ack", 64'(ack), 64'd0);
            next_cycle();
        end
        resend = 1'b0;
        @(negedge clk);
        chk("rs_emit", 64'(dout), 64'(pkt(7'd4, 32'h55)));
        chk("rs_emit_ack", 64'(ack), 64'd0);
        next_cycle();
        @(negedge clk);
        chk("rs_once", 64'(dout), 64'd0);
        chk("rs_sent", 64'(sent_cnt), 64'd5);
        chk("rs_credit", 64'(credit_cnt), 64'd123);
        next_cycle();

        // Reset while a packet is pending.
        vld = 1'b1; data = 32'h77;
        next_cycle();
        vld = 1'b0;
        chk("mid_pending", 64'(dout), 64'(pkt(7'd5, 32'h77)));
        reset = 1'b1;
        #1;
        chk("mid_rst_dout", 64'(dout), 64'd0);
        chk("mid_rst_credit", 64'(credit_cnt), 64'd128);
        next_cycle();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("mid_post_dout", 64'(dout), 64'd0);
            next_cycle();
        end
        chk("mid_post_sent", 64'(sent_cnt), 64'd0);

        // Credit exhaustion, one update, wptr wrap across 192 packets.
        do_reset();
        send_cfg();
        acc = 0; emit = 0;
        stream(300);
        chk("exh_accepts", 64'(acc), 64'd128);
        chk("exh_credit", 64'(credit_cnt), 64'd0);
        s0 = stall_cnt;
        stream(10);
        chk("exh_stall_inc", 64'(stall_cnt - s0), 64'd10);
        chk("exh_no_more", 64'(acc), 64'd128);
        din_ctrl = UPD_PKT;
        stream(1);
        din_ctrl = '0;
        chk("upd_credit", 64'(credit_cnt), 64'd64);
        stream(200);
        chk("upd_accepts", 64'(acc), 64'd192);
        chk("upd_emits", 64'(emit), 64'd192);
        chk("upd_sent", 64'(sent_cnt), 64'd192);
        chk("upd_credit0", 64'(credit_cnt), 64'd0);
        vld = 1'b0;

        // Simultaneous accept and update at credit 100 clamps to 128.
        do_reset();
        chk("clr_ovf", 64'(credit_overflow), 64'd0);
        send_cfg();
        acc = 0;
        for (int i = 0; i < 100 && acc < 28; i++) begin
            vld = 1'b1; data = 32'(i);
            @(negedge clk);
            if (ack) acc++;
            next_cycle();
        end
        vld = 1'b0;
        chk("clamp_pre_acc", 64'(acc), 64'd28);
        chk("clamp_pre_credit", 64'(credit_cnt), 64'd100);
        next_cycle();
        vld = 1'b1; din_ctrl = UPD_PKT;
        @(negedge clk);
        chk("clamp_ack", 64'(ack), 64'd1);
        next_cycle();
        vld = 1'b0; din_ctrl = '0;
        chk("clamp_credit", 64'(credit_cnt), 64'd128);
        chk("clamp_ovf", 64'(credit_overflow), 64'd1);
        for (int i = 0; i < 5; i++) next_cycle();
        chk("clamp_ovf_sticky", 64'(credit_overflow), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
